// File: rtl/tlb_search_arb.sv
// Purpose : shares one combinational TLB search port among fetch (F), load/store (M)
//           and tlbsrch (C) requesters, and registers the result for the winner.
// Latency : grant is combinational in the request cycle; rsp_v rises 1 cycle after grant.
// Backpr. : F/M hold rsp_v and r_* stable until their ack; ungranted requests wait at the requester.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   f_req/f_va/f_gnt/f_rsp_v/f_ack   fetch requester (flushable)
//   m_req/m_va/m_gnt/m_rsp_v/m_ack   load/store requester
//   c_req/c_vppn/c_gnt/c_rsp_v       tlbsrch requester, single-cycle response, no ack
//   asid, flush         current ASID and pipeline flush
//   s_vppn/s_va_bit12/s_asid         search key towards the TLB
//   s_found..s_v        combinational TLB result
//   r_found..r_v        registered result shared by all requesters
//
// Build option: define TLB_ARB_RR_EN to make M and F alternate round-robin below C;
// without it the order is fixed C > M > F.

module tlb_search_arb #(
  parameter  int TLBNUM = 16,
  localparam int IW     = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic          clk,
  input  logic          reset,

  // fetch requester
  input  logic          f_req,
  input  logic [31:0]   f_va,
  output logic          f_gnt,
  output logic          f_rsp_v,
  input  logic          f_ack,

  // load/store requester
  input  logic          m_req,
  input  logic [31:0]   m_va,
  output logic          m_gnt,
  output logic          m_rsp_v,
  input  logic          m_ack,

  // tlbsrch requester
  input  logic          c_req,
  input  logic [18:0]   c_vppn,
  output logic          c_gnt,
  output logic          c_rsp_v,

  input  logic [9:0]    asid,
  input  logic          flush,

  // search port towards the TLB
  output logic [18:0]   s_vppn,
  output logic          s_va_bit12,
  output logic [9:0]    s_asid,

  // combinational TLB result
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  input  logic [19:0]   s_ppn,
  input  logic [5:0]    s_ps,
  input  logic [1:0]    s_plv,
  input  logic [1:0]    s_mat,
  input  logic          s_d,
  input  logic          s_v,

  // registered result
  output logic          r_found,
  output logic [IW-1:0] r_index,
  output logic [19:0]   r_ppn,
  output logic [5:0]    r_ps,
  output logic [1:0]    r_plv,
  output logic [1:0]    r_mat,
  output logic          r_d,
  output logic          r_v
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOK = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_F = 2'd0,
    OWN_M = 2'd1,
    OWN_C = 2'd2
  } owner_t;

  state_t state, state_nxt;
  owner_t owner, owner_nxt;

  // The low page-offset bits are not part of the search key.
  logic unused_va_lo;
  assign unused_va_lo = ^{f_va[11:0], m_va[11:0]};

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  // Grants are combinational from IDLE; reset is folded in so that no
  // grant (and hence no search key) is presented while reset is held.
  logic idle;
  logic busy;
  logic f_elig;   // fetch request that survives a flush
  logic m_win;    // M wins the M/F contest (C not considered)
  logic f_win;    // F wins the M/F contest (C not considered)

  assign idle   = (state == IDLE) && !reset;
  assign busy   = (state == LOOK) || (state == HOLD);
  assign f_elig = f_req && !flush;

`ifdef TLB_ARB_RR_EN
  // rr_ptr = 0 prefers M, 1 prefers F. After an M or F grant it points
  // at the side that was not granted.
  logic rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (m_gnt) begin
      rr_ptr <= 1'b1;
    end else if (f_gnt) begin
      rr_ptr <= 1'b0;
    end
  end

  assign m_win = m_req  && (!f_elig || !rr_ptr);
  assign f_win = f_elig && (!m_req  ||  rr_ptr);
`else
  assign m_win = m_req;
  assign f_win = f_elig && !m_req;
`endif

  always_comb begin
    c_gnt = 1'b0;
    m_gnt = 1'b0;
    f_gnt = 1'b0;
    if (idle) begin
      c_gnt = c_req;
      m_gnt = !c_req && m_win;
      f_gnt = !c_req && f_win;
    end
  end

  logic any_gnt;
  assign any_gnt = c_gnt || m_gnt || f_gnt;

  // ------------------------------------------------------------------
  // Search key mux: driven only while a grant is being issued
  // ------------------------------------------------------------------
  always_comb begin
    s_vppn     = '0;
    s_va_bit12 = 1'b0;
    s_asid     = '0;
    if (c_gnt) begin
      s_vppn     = c_vppn;
      s_va_bit12 = 1'b0;
      s_asid     = asid;
    end else if (m_gnt) begin
      s_vppn     = m_va[31:13];
      s_va_bit12 = m_va[12];
      s_asid     = asid;
    end else if (f_gnt) begin
      s_vppn     = f_va[31:13];
      s_va_bit12 = f_va[12];
      s_asid     = asid;
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_F;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (c_gnt) begin
          state_nxt = LOOK;
          owner_nxt = OWN_C;
        end else if (m_gnt) begin
          state_nxt = LOOK;
          owner_nxt = OWN_M;
        end else if (f_gnt) begin
          state_nxt = LOOK;
          owner_nxt = OWN_F;
        end
      end
      LOOK, HOLD: begin
        case (owner)
          // tlbsrch has no ack: its response is a single-cycle pulse.
          OWN_C:   state_nxt = IDLE;
          OWN_M:   state_nxt = m_ack ? IDLE : HOLD;
          // A flush kills an outstanding fetch lookup outright.
          default: state_nxt = (flush || f_ack) ? IDLE : HOLD;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response valids follow the owner; f_rsp_v is masked by flush in the
  // same cycle so the fetch stage never sees a stale translation.
  assign f_rsp_v = busy && (owner == OWN_F) && !flush;
  assign m_rsp_v = busy && (owner == OWN_M);
  assign c_rsp_v = busy && (owner == OWN_C);

  // ------------------------------------------------------------------
  // Result register: captured only on a grant, so it stays frozen
  // through LOOK and HOLD regardless of what the TLB presents.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_found <= 1'b0;
      r_index <= '0;
      r_ppn   <= '0;
      r_ps    <= '0;
      r_plv   <= '0;
      r_mat   <= '0;
      r_d     <= 1'b0;
      r_v     <= 1'b0;
    end else if (any_gnt) begin
      r_found <= s_found;
      r_index <= s_index;
      r_ppn   <= s_ppn;
      r_ps    <= s_ps;
      r_plv   <= s_plv;
      r_mat   <= s_mat;
      r_d     <= s_d;
      r_v     <= s_v;
    end
  end

endmodule

// File: tb/tb_tlb_search_arb.sv
module tb_tlb_search_arb;

  localparam int IW = 4;
  localparam int RW = 33 + IW;

  logic clk = 1'b0;
  logic reset;
  logic f_req, m_req, c_req, f_ack, m_ack, flush;
  logic [31:0] f_va, m_va;
  logic [18:0] c_vppn;
  logic [9:0]  asid;
  logic f_gnt, m_gnt, c_gnt, f_rsp_v, m_rsp_v, c_rsp_v;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic s_found, s_d, s_v;
  logic [IW-1:0] s_index;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv, s_mat;
  logic r_found, r_d, r_v;
  logic [IW-1:0] r_index;
  logic [19:0] r_ppn;
  logic [5:0]  r_ps;
  logic [1:0]  r_plv, r_mat;

  logic [RW-1:0] tlb_res;
  assign {s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v} = tlb_res;

  wire [RW-1:0] r_all = {r_found, r_index, r_ppn, r_ps, r_plv, r_mat, r_d, r_v};
  wire [1:0] rsp_src = f_rsp_v ? 2'd0 : m_rsp_v ? 2'd1 : c_rsp_v ? 2'd2 : 2'd3;
  wire [2:0] gnt = {c_gnt, m_gnt, f_gnt};
  wire [2:0] rsp = {f_rsp_v, m_rsp_v, c_rsp_v};

  int total = 0;
  int bad   = 0;
  logic [RW+1:0] sb_q[$];
  logic [RW+1:0] exp_e;

  tlb_search_arb #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_va(f_va), .f_gnt(f_gnt), .f_rsp_v(f_rsp_v), .f_ack(f_ack),
    .m_req(m_req), .m_va(m_va), .m_gnt(m_gnt), .m_rsp_v(m_rsp_v), .m_ack(m_ack),
    .c_req(c_req), .c_vppn(c_vppn), .c_gnt(c_gnt), .c_rsp_v(c_rsp_v),
    .asid(asid), .flush(flush),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
    .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .r_found(r_found), .r_index(r_index), .r_ppn(r_ppn), .r_ps(r_ps),
    .r_plv(r_plv), .r_mat(r_mat), .r_d(r_d), .r_v(r_v)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rnd_res();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    f_req = 0; m_req = 0; c_req = 0; f_ack = 0; m_ack = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; f_req = 1; m_req = 1; c_req = 1; f_ack = 0; m_ack = 0; flush = 0;
    f_va = $urandom(); m_va = $urandom(); c_vppn = 19'h7abcd; asid = 10'h155;
    tlb_res = rnd_res();
    tick(); settle();
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b want=000", gnt); end
    total++; if (rsp !== 3'b000) begin bad++; $display("FAIL reset_rsp got=%b want=000", rsp); end
    total++; if (r_all !== '0) begin bad++; $display("FAIL reset_r got=%h want=0", r_all); end
    total++; if ({s_vppn, s_va_bit12, s_asid} !== 30'd0) begin bad++; $display("FAIL reset_s got=%h want=0", {s_vppn, s_va_bit12, s_asid}); end
    idle_inputs();
    reset = 0;
    tick();
  endtask

  task automatic test_prio_mf();
    f_req = 1; m_req = 1; f_va = $urandom(); m_va = $urandom(); asid = 10'h2c3;
    tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL mf_gnt got=%b want=010", gnt); end
    total++; if (s_vppn !== m_va[31:13]) begin bad++; $display("FAIL mf_s_vppn got=%h want=%h", s_vppn, m_va[31:13]); end
    total++; if (s_va_bit12 !== m_va[12]) begin bad++; $display("FAIL mf_s_bit12 got=%b want=%b", s_va_bit12, m_va[12]); end
    total++; if (s_asid !== 10'h2c3) begin bad++; $display("FAIL mf_s_asid got=%h want=2c3", s_asid); end
    sb_q.push_back({2'd1, tlb_res});
    tick(); tlb_res = rnd_res(); m_ack = 1; settle();
    total++; if (rsp !== 3'b010) begin bad++; $display("FAIL mf_m_rsp got=%b want=010", rsp); end
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL mf_look_gnt got=%b want=000", gnt); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL mf_m_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL mf_m_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); m_req = 0; m_ack = 0; tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL mf_f_gnt got=%b want=001", gnt); end
    total++; if ({s_vppn, s_va_bit12} !== f_va[31:12]) begin bad++; $display("FAIL mf_f_key got=%h want=%h", {s_vppn, s_va_bit12}, f_va[31:12]); end
    sb_q.push_back({2'd0, tlb_res});
    tick(); f_ack = 1; tlb_res = rnd_res(); settle();
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL mf_f_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL mf_f_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); idle_inputs(); settle();
    total++; if (rsp !== 3'b000) begin bad++; $display("FAIL mf_end_rsp got=%b want=000", rsp); end
    tick();
  endtask

  task automatic test_hold();
    int n = 0;
    f_req = 1; f_va = $urandom(); tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL hold_gnt got=%b want=001", gnt); end
    sb_q.push_back({2'd0, tlb_res});
    tick();
    for (int i = 0; i < 3; i++) begin
      tlb_res = rnd_res(); settle();
      if (f_rsp_v) n++;
      exp_e = sb_q[0];
      total++; if (r_all !== exp_e[RW-1:0]) begin bad++; $display("FAIL hold_frozen[%0d] got=%h want=%h", i, r_all, exp_e[RW-1:0]); end
      tick();
    end
    f_ack = 1; tlb_res = rnd_res(); settle();
    if (f_rsp_v) n++;
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL hold_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL hold_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); f_ack = 0; tlb_res = rnd_res(); settle();
    total++; if (n !== 4) begin bad++; $display("FAIL hold_rsp_cycles got=%0d want=4", n); end
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL hold_idle_regrant got=%b want=001", gnt); end
    sb_q.push_back({2'd0, tlb_res});
    tick(); f_ack = 1; settle();
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL hold_sb2 queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL hold_sb2 got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_c_prio();
    c_req = 1; c_vppn = 19'h12345; m_req = 1; f_req = 1;
    m_va = $urandom(); f_va = $urandom(); tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL c_gnt got=%b want=100", gnt); end
    total++; if (s_vppn !== 19'h12345) begin bad++; $display("FAIL c_s_vppn got=%h want=12345", s_vppn); end
    total++; if (s_va_bit12 !== 1'b0) begin bad++; $display("FAIL c_s_bit12 got=%b want=0", s_va_bit12); end
    sb_q.push_back({2'd2, tlb_res});
    tick(); c_req = 0; tlb_res = rnd_res(); settle();
    total++; if (rsp !== 3'b001) begin bad++; $display("FAIL c_rsp got=%b want=001", rsp); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL c_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL c_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); tlb_res = rnd_res(); settle();
    total++; if (rsp !== 3'b000) begin bad++; $display("FAIL c_pulse got=%b want=000", rsp); end
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL c_then_m got=%b want=010", gnt); end
    sb_q.push_back({2'd1, tlb_res});
    tick(); m_ack = 1; settle();
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL c_m_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL c_m_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); m_req = 0; m_ack = 0; tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL c_then_f got=%b want=001", gnt); end
    sb_q.push_back({2'd0, tlb_res});
    tick(); f_ack = 1; settle();
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL c_f_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL c_f_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_flush();
    // owner F: flush kills the response
    f_req = 1; f_va = $urandom(); tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL fl_f_gnt got=%b want=001", gnt); end
    sb_q.push_back({2'd0, tlb_res});
    tick(); settle();
    tick(); settle();
    total++; if (f_rsp_v !== 1'b1) begin bad++; $display("FAIL fl_f_hold_rsp got=%b want=1", f_rsp_v); end
    flush = 1; #1;
    total++; if (f_rsp_v !== 1'b0) begin bad++; $display("FAIL fl_f_rsp_kill got=%b want=0", f_rsp_v); end
    void'(sb_q.pop_front());
    tick(); tlb_res = rnd_res(); settle();
    total++; if ({gnt, rsp} !== 6'b0) begin bad++; $display("FAIL fl_idle_suppress got=%b want=000000", {gnt, rsp}); end
    flush = 0; #1;
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL fl_idle_after got=%b want=001", gnt); end
    sb_q.push_back({2'd0, tlb_res});
    tick(); f_ack = 1; settle();
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL fl_f_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL fl_f_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); idle_inputs(); tick();
    // owner M: flush and a stray f_ack are ignored
    m_req = 1; m_va = $urandom(); tlb_res = rnd_res(); settle();
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL fl_m_gnt got=%b want=010", gnt); end
    sb_q.push_back({2'd1, tlb_res});
    tick(); tick(); flush = 1; f_ack = 1; settle();
    total++; if (rsp !== 3'b010) begin bad++; $display("FAIL fl_m_rsp got=%b want=010", rsp); end
    tick(); settle();
    total++; if (rsp !== 3'b010) begin bad++; $display("FAIL fl_m_rsp_stay got=%b want=010", rsp); end
    m_ack = 1; #1;
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL fl_m_sb queue empty"); end
    else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL fl_m_sb got=%h want=%h", {rsp_src, r_all}, exp_e); end end
    tick(); idle_inputs(); settle();
    total++; if (rsp !== 3'b000) begin bad++; $display("FAIL fl_m_done got=%b want=000", rsp); end
    tick();
  endtask

  task automatic test_reset_hold();
    f_req = 1; f_va = $urandom(); tlb_res = rnd_res(); tlb_res[RW-1] = 1'b1; settle();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL rh_gnt got=%b want=001", gnt); end
    sb_q.push_back({2'd0, tlb_res});
    tick(); tick(); settle();
    total++; if ({f_rsp_v, r_found} !== 2'b11) begin bad++; $display("FAIL rh_pre got=%b want=11", {f_rsp_v, r_found}); end
    reset = 1; #1;
    total++; if ({gnt, rsp} !== 6'b0) begin bad++; $display("FAIL rh_async got=%b want=000000", {gnt, rsp}); end
    total++; if (r_found !== 1'b0) begin bad++; $display("FAIL rh_r_found got=%b want=0", r_found); end
    sb_q.delete();
    tick(); reset = 0; f_req = 0; settle();
    total++; if (rsp !== 3'b000) begin bad++; $display("FAIL rh_release got=%b want=000", rsp); end
    tick(); settle();
    total++; if (rsp !== 3'b000) begin bad++; $display("FAIL rh_release2 got=%b want=000", rsp); end
    tick();
  endtask

  task automatic test_back_to_back();
    int nf = 0;
    int nm = 0;
    logic [1:0] want;
    f_req = 1; m_req = 1; f_ack = 1; m_ack = 1;
    for (int i = 0; i < 8; i++) begin
`ifdef TLB_ARB_RR_EN
      want = (i % 2 == 0) ? 2'd1 : 2'd0;
`else
      want = 2'd1;
`endif
      f_va = $urandom(); m_va = $urandom(); tlb_res = rnd_res(); settle();
      if (m_gnt) nm++;
      if (f_gnt) nf++;
      total++; if (gnt !== ((want == 2'd1) ? 3'b010 : 3'b001)) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b want_src=%0d", i, gnt, want); end
      sb_q.push_back({want, tlb_res});
      tick(); tlb_res = rnd_res(); settle();
      total++;
      if (sb_q.size() == 0) begin bad++; $display("FAIL b2b_sb[%0d] queue empty", i); end
      else begin exp_e = sb_q.pop_front(); if ({rsp_src, r_all} !== exp_e) begin bad++; $display("FAIL b2b_sb[%0d] got=%h want=%h", i, {rsp_src, r_all}, exp_e); end end
      tick();
    end
`ifdef TLB_ARB_RR_EN
    total++; if ({nm, nf} !== {32'd4, 32'd4}) begin bad++; $display("FAIL b2b_share got=m%0d/f%0d want=m4/f4", nm, nf); end
`else
    total++; if ({nm, nf} !== {32'd8, 32'd0}) begin bad++; $display("FAIL b2b_share got=m%0d/f%0d want=m8/f0", nm, nf); end
`endif
    idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_prio_mf();
    test_hold();
    test_c_prio();
    test_flush();
    test_reset_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
